reg_move_unit: RTL
==================

Name: reg_move_unit

Overview:
- Command-driven register-to-register move engine built around a DEPTH x N register bank.
- Consumes the bit-parallel moves that the datapath's per-bit move cells only drive outward. It captures them into addressed registers and executes MOV, SWAP and CLR commands over a valid/ready handshake.
- Sits between the instruction decoder (command side) and the ALU/writeback path (external write and read ports).

Parameters:
N, 4, data width of each register in bits
A, 2, register address width; bank holds DEPTH = 2**A registers

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
ext_we  input  1  external write enable
ext_waddr  input  A  external write address
ext_wdata  input  N  external write data
rd_addr  input  A  read port address
rd_data  output  N  combinational read: reg[rd_addr]
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command
cmd_op  input  2  00 MOV, 01 SWAP, 10 CLR, 11 NOP
cmd_src  input  A  source register (MOV/SWAP)
cmd_dst  input  A  destination register (MOV/SWAP/CLR)
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - All registers cleared to 0.
  - FSM forced to IDLE; done=0, busy=0, cmd_ready=1 (derived from IDLE).
  - Latched op/src/dst and temps cleared.
- Reset mid-command: command abandoned, no done pulse, bank cleared.
- FSM states: IDLE, RD, WR_DST, WR_SRC, DONE.
  - cmd_ready = (state==IDLE).
  - busy = (state!=IDLE).
  - done = (state==DONE), registered from the state.
- Accept: on a rising edge with cmd_valid & cmd_ready, latch op/src/dst. Next state by op:
  - MOV/SWAP -> RD.
  - CLR -> WR_DST.
  - NOP -> DONE.
- RD: tmp_a <= reg[src], tmp_b <= reg[dst]. Next state WR_DST.
- WR_DST: reg[dst] <= tmp_a (MOV/SWAP) or 0 (CLR). Next state WR_SRC if SWAP, else DONE.
- WR_SRC: reg[src] <= tmp_b. Next state DONE.
- DONE: done=1 for exactly one cycle. Next state IDLE. No command accepted in DONE.
- Latency, accept edge to done-high cycle (counting cycles after the accept edge):
  - MOV: done in cycle 3, ready again in cycle 4.
  - SWAP: done in cycle 4.
  - CLR: done in cycle 2.
  - NOP: done in cycle 1.
- cmd_* inputs are ignored outside IDLE. cmd_valid held high across completion is accepted again in IDLE; each accept yields one command.
- src==dst: MOV and SWAP leave the register unchanged and still run the full sequence and pulse done.
- External writes:
  - Accepted in any state, including while busy. Written on the edge with ext_we=1.
  - Same-edge collision with an engine write to the same address: the engine write wins, the external write is dropped.
  - An external write to src or dst after the RD edge does not affect the values already latched in tmps.
- rd_data is combinational. It reflects a write from the cycle after the write edge; there is no write-through bypass.
- Address arithmetic is unsigned A-bit. All addresses 0..DEPTH-1 are valid, and register 0 is ordinary, not hardwired.

Test Plan:
- Reset, then ext-write reg1=0x5, reg2=0xA. Read rd_addr=1 -> 0x5, rd_addr=2 -> 0xA. Assert rst_n low mid-cycle -> all reads 0, cmd_ready=1 immediately.
- MOV src=1 dst=3 accepted at edge 0 -> busy in cycles 1-3, done high only in cycle 3, reg3=0x5, reg1=0x5, cmd_ready=1 in cycle 4.
- SWAP src=1 dst=2 (0x5/0xA) -> done in cycle 4, reg1=0xA, reg2=0x5. SWAP with src=dst=2 -> reg2 unchanged, done still pulses.
- CLR dst=1 -> done in cycle 2, reg1=0. NOP -> done in cycle 1, bank unchanged. Back-to-back cmd_valid held high for 2 MOVs -> exactly 2 done pulses, second accepted in the cycle after the first done.
- Collision: during MOV 1->3, ext_we to addr 3 with 0xF on the WR_DST edge -> reg3 = MOV value. ext_we to addr 0 with 0x7 on the same edge -> reg0=0x7.
- Reset asserted in the RD state of a SWAP -> no done pulse, state IDLE, all registers 0, next command accepted normally after release.

Source files
------------

// File: rtl/reg_move_unit.sv
// Command-driven move engine over a DEPTH x N register bank: MOV, SWAP and CLR
// commands run a short FSM while an external write port stays live in every state.
module reg_move_unit #(
    parameter int N = 4,
    parameter int A = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ext_we,
    input  logic [A-1:0] ext_waddr,
    input  logic [N-1:0] ext_wdata,
    input  logic [A-1:0] rd_addr,
    output logic [N-1:0] rd_data,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [A-1:0] cmd_src,
    input  logic [A-1:0] cmd_dst,
    output logic         busy,
    output logic         done
);
    localparam int DEPTH = 1 << A;

    localparam logic [1:0] OP_MOV  = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_CLR  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_WR_DST = 3'd2,
        S_WR_SRC = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [A-1:0]   src_q, src_d;
    logic [A-1:0]   dst_q, dst_d;
    logic [N-1:0]   tmp_a_q, tmp_a_d;
    logic [N-1:0]   tmp_b_q, tmp_b_d;
    logic [N-1:0]   bank_q [DEPTH];
    logic [N-1:0]   bank_d [DEPTH];

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, so cmd_* is
    // ignored in every other state and each transfer starts exactly one command.
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rd_data   = bank_q[rd_addr];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        tmp_a_d = tmp_a_q;
        tmp_b_d = tmp_b_q;
        bank_d  = bank_q;

        // External write goes first so an engine write to the same address overrides it.
        if (ext_we) begin
            bank_d[ext_waddr] = ext_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    case (cmd_op)
                        OP_MOV, OP_SWAP: state_d = S_RD;
                        OP_CLR:          state_d = S_WR_DST;
                        default:         state_d = S_DONE;
                    endcase
                end
            end
            S_RD: begin
                tmp_a_d = bank_q[src_q];
                tmp_b_d = bank_q[dst_q];
                state_d = S_WR_DST;
            end
            S_WR_DST: begin
                bank_d[dst_q] = (op_q == OP_CLR) ? '0 : tmp_a_q;
                state_d       = (op_q == OP_SWAP) ? S_WR_SRC : S_DONE;
            end
            S_WR_SRC: begin
                bank_d[src_q] = tmp_b_q;
                state_d       = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            tmp_a_q <= '0;
            tmp_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            tmp_a_q <= tmp_a_d;
            tmp_b_q <= tmp_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

endmodule
